// File: rtl/dmem_pkg.sv
// Shared funct3 encodings and FSM state type for the data-memory stage.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_INIT, ST_RUN} dmem_state_t;

endpackage

// File: rtl/dmem_lane_gen.sv
// Byte-enable, lane-shifted write data and misalignment decode for one access.
module dmem_lane_gen
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic        is_store,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    byte_en    = '0;
    wdata      = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_B: begin
        // Replicating the byte into every lane lets byte_en alone pick the target.
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{rs2_data[7:0]}};
      end
      F3_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rs2_data[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        byte_en    = 4'b1111;
        wdata      = rs2_data;
        misaligned = |addr_lo;
      end
      F3_BU: misaligned = is_store;
      F3_HU: misaligned = is_store | addr_lo[0];
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Word-organised data memory with self-clearing init sweep, access counters
// and first-fault capture for misaligned or illegal accesses.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_out,
  output logic        ready,
  output logic        misaligned,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t   state, next_state;
  logic [AW-1:0] idx, next_idx;
  logic          init_we;

  logic [AW-1:0] index;
  logic          access;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic          lane_mis;
  logic          store_en;
  logic          load_acc;

  assign index  = address[AW+1:2];
  assign access = mem_read | mem_write;

  dmem_lane_gen u_lane_gen (
    .funct3     (funct3),
    .addr_lo    (address[1:0]),
    .rs2_data   (rs2_data),
    .is_store   (mem_write),
    .byte_en    (byte_en),
    .wdata      (wdata),
    .misaligned (lane_mis)
  );

  assign ready      = (state == ST_RUN);
  assign misaligned = access & lane_mis;

  // Read+write together is a store: mem_out shows the pre-write word, only store_count moves.
  assign store_en = ready & mem_write & ~lane_mis & ~reset;
  assign load_acc = ready & mem_read & ~mem_write & ~lane_mis;

  assign mem_out = (ready && mem_read && !lane_mis) ? mem[index] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    init_we    = 1'b0;
    case (state)
      ST_INIT: begin
        init_we  = 1'b1;
        next_idx = idx + AW'(1);
        if (idx == LAST_IDX) next_state = ST_RUN;
      end
      ST_RUN: ;
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init_we && !reset) begin
      mem[idx] <= '0;
    end else if (store_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else begin
      if (load_acc) load_count <= load_count + 32'd1;
      if (store_en) store_count <= store_count + 32'd1;
      if (ready && misaligned && !fault_valid) begin
        fault_valid <= 1'b1;
        fault_addr  <= address;
      end
    end
  end

endmodule
